// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Contents:
//   state_e   - scan FSM state (S_BLANK, S_DRIVE)
//   SEG_BLANK - all segments off
//   SEG_HEX   - hex glyphs 0..F, bit order [6]=a .. [0]=g, active-high
package seg_scan_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Element 0 is the rightmost entry, so SEG_HEX[n] is the glyph for n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,  // F E d C
    7'h1F, 7'h77, 7'h7B, 7'h7F,  // b A 9 8
    7'h70, 7'h5F, 7'h5B, 7'h33,  // 7 6 5 4
    7'h79, 7'h6D, 7'h30, 7'h7E   // 3 2 1 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment decoder.
// Ports:
//   hex - 4-bit digit value 0..F
//   seg - segment pattern, [6]=a .. [0]=g, active-high
module seg7_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment
// display. Each digit slot starts with a blanking gap (all digits off) and then
// drives one digit from the active registers through a single shared decoder.
// Digit values are staged in shadow registers and copied to the active set
// atomically at the end of a frame once a commit is pending.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   wr_en/wr_idx/wr_data - shadow register write (out-of-range index ignored)
//   commit         - request shadow->active transfer at next frame boundary
//   commit_pending - transfer requested but not yet performed
//   seg_out        - segment bus, [6]=a .. [0]=g, active-high
//   dig_en         - one-hot digit enable, active-high
//   frame_tick     - high during the last cycle of each frame
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50_000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = 32,
  localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            shadow_q [NUM_DIGITS];
  logic [3:0]            shadow_d [NUM_DIGITS];
  logic [3:0]            active_q [NUM_DIGITS];
  logic [3:0]            active_d [NUM_DIGITS];
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  tick_q, tick_d;

  logic                  cnt_last, idx_last;
  logic [3:0]            cur_val;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_mask;

  assign cnt_last = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign cur_val  = active_q[idx_q];

  seg7_hex_decode u_dec (
    .hex (cur_val),
    .seg (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  // A digit above 0 is blanked when it and every higher digit are zero.
  logic zero_run;
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_q[i] == 4'd0);
      if (i > 0) lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Slot timing FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    if (cnt_last) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    unique case (state_q)
      S_BLANK: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = S_DRIVE;
      S_DRIVE: if (cnt_last) state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
  end

  // Registered outputs reflect the slot position of the current cycle.
  always_comb begin
    seg_d  = SEG_BLANK;
    dig_d  = '0;
    tick_d = cnt_last & idx_last;
    if (state_q == S_DRIVE) begin
      dig_d = NUM_DIGITS'(1) << idx_q;
      seg_d = lz_mask[idx_q] ? SEG_BLANK : dec_seg;
    end
  end

  // Shadow writes, commit tracking and frame-boundary transfer. tick_q is
  // high during the boundary cycle, so the transfer uses pre-edge shadow data
  // and a commit arriving in that cycle stays pending for the next frame.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (32'(wr_idx) < 32'(NUM_DIGITS))) shadow_d[wr_idx] = wr_data;
    active_d = (tick_q && pend_q) ? shadow_q : active_q;
    pend_d   = commit | (pend_q & ~tick_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      pend_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
      dig_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end
  end

  assign commit_pending = pend_q;
  assign seg_out        = seg_q;
  assign dig_en         = dig_q;
  assign frame_tick     = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (4 digits, dwell 8, blank 2).
// "Cycle n" outputs are sampled 1 time unit after rising edge n; inputs set at
// that point are sampled by edge n+1 (i.e. they are "cycle n" inputs).
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;

`ifdef SEG_SCAN_LZB_EN
  localparam logic [6:0] LZ0 = 7'h00;
`else
  localparam logic [6:0] LZ0 = 7'h7E;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_idx = '0;
  logic [3:0]    wr_data = '0;
  logic          commit = 1'b0;
  logic          commit_pending;
  logic [6:0]    seg_out;
  logic [ND-1:0] dig_en;
  logic          frame_tick;

  int cyc = -1;
  int n_pass = 0;
  int n_total = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2),
    .CNT_W        (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .seg_out        (seg_out),
    .dig_en         (dig_en),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] de, input logic [6:0] sg);
    chk({tag, ".dig_en"}, 32'(dig_en), 32'(de));
    chk({tag, ".seg_out"}, 32'(seg_out), 32'(sg));
  endtask

  task automatic wr(input logic [1:0] i, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_idx  = i;
    wr_data = d;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_disp("rst", 4'b0000, 7'h00);
    chk("rst.tick", 32'(frame_tick), 0);
    chk("rst.pend", 32'(commit_pending), 0);
    rst = 1'b0;
    cyc = -1;

    // Frame 0: scan timing with all-zero active digits
    step_to(0);  chk_disp("c0", 4'b0000, 7'h00);
    step_to(1);  chk_disp("c1", 4'b0000, 7'h00);
    wr(2'd0, 4'd4);
    step_to(2);  chk_disp("c2", 4'b0001, 7'h7E);
    wr(2'd1, 4'd2);
    step_to(3);  wr(2'd2, 4'd3);
    step_to(4);  wr(2'd3, 4'd1);
    step_to(5);
    wr_en = 1'b0; commit = 1'b1;
    chk("c5.pend", 32'(commit_pending), 0);
    step_to(6);
    commit = 1'b0;
    chk("c6.pend", 32'(commit_pending), 1);
    step_to(7);  chk_disp("c7", 4'b0001, 7'h7E);
    step_to(8);  chk_disp("c8", 4'b0000, 7'h00);
    step_to(10); chk_disp("c10", 4'b0010, LZ0);
    step_to(30); chk("c30.tick", 32'(frame_tick), 0);
    step_to(31);
    chk("c31.tick", 32'(frame_tick), 1);
    chk("c31.pend", 32'(commit_pending), 1);
    chk_disp("c31", 4'b1000, LZ0);

    // Frame 1: committed values 4,2,3,1 shown
    step_to(32);
    chk("c32.pend", 32'(commit_pending), 0);
    chk("c32.tick", 32'(frame_tick), 0);
    step_to(34); chk_disp("c34", 4'b0001, 7'h33);
    step_to(40); wr(2'd0, 4'd7);
    step_to(41); wr(2'd1, 4'd0);
    step_to(42);
    chk_disp("c42", 4'b0010, 7'h6D);
    wr(2'd2, 4'd0);
    step_to(43); wr(2'd3, 4'd0);
    step_to(44); wr_en = 1'b0;
    step_to(50); chk_disp("c50", 4'b0100, 7'h79);
    step_to(58); chk_disp("c58", 4'b1000, 7'h30);

    // Commit only in the frame_tick cycle: transfer deferred one frame
    step_to(63);
    chk("c63.tick", 32'(frame_tick), 1);
    chk("c63.pend", 32'(commit_pending), 0);
    commit = 1'b1;
    step_to(64);
    commit = 1'b0;
    chk("c64.pend", 32'(commit_pending), 1);
    step_to(66); chk_disp("c66", 4'b0001, 7'h33);
    step_to(95); chk("c95.pend", 32'(commit_pending), 1);
    step_to(96); chk("c96.pend", 32'(commit_pending), 0);

    // Active = {0,0,0,7}
    step_to(98); chk_disp("c98", 4'b0001, 7'h70);
    // Write and commit in the same non-boundary cycle
    step_to(100);
    wr(2'd1, 4'hA); commit = 1'b1;
    step_to(101);
    wr_en = 1'b0; commit = 1'b0;
    step_to(106); chk_disp("c106", 4'b0010, LZ0);
    step_to(114); chk_disp("c114", 4'b0100, LZ0);
    step_to(122); chk_disp("c122", 4'b1000, LZ0);

    // Active = {0,0,A,7}
    step_to(130); chk_disp("c130", 4'b0001, 7'h70);
    step_to(138); chk_disp("c138", 4'b0010, 7'h77);
    step_to(139); commit = 1'b1;
    step_to(140);
    commit = 1'b0;
    chk("c140.pend", 32'(commit_pending), 1);
    chk_disp("c140", 4'b0010, 7'h77);
    rst = 1'b1;
    step_to(141);
    chk_disp("r141", 4'b0000, 7'h00);
    chk("r141.pend", 32'(commit_pending), 0);
    chk("r141.tick", 32'(frame_tick), 0);
    rst = 1'b0;
    cyc = -1;

    // After reset: timing restarts, active and shadow cleared
    step_to(0);
    commit = 1'b1;
    chk_disp("n0", 4'b0000, 7'h00);
    step_to(1);
    commit = 1'b0;
    chk_disp("n1", 4'b0000, 7'h00);
    step_to(2);  chk_disp("n2", 4'b0001, 7'h7E);
    step_to(10); chk_disp("n10", 4'b0010, LZ0);
    step_to(31); chk("n31.tick", 32'(frame_tick), 1);
    step_to(34); chk_disp("n34", 4'b0001, 7'h7E);
    step_to(42); chk_disp("n42", 4'b0010, LZ0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
